max_pool_unit: RTL and testbench

Streaming window reducer that sits directly downstream of the pooling address iterator and its feature-map SRAM. It consumes the iterator's active-low enable and first/last window flags, aligns them to the SRAM read data, and keeps a signed running maximum per window. It writes one result per window to the output feature buffer at sequential addresses and pulses `done` after the last result of the layer.

---
 rtl/max_pool_unit.sv | 159 +++++++++++++++
 tb/tb_max_pool_unit.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_unit.sv
// Streaming signed max-pool reducer: aligns iterator flags to SRAM read data and
// writes one window maximum per window. Optional build macro: POOL_RELU_EN.
module max_pool_unit #(
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1,
    parameter int NUM_OUTPUTS = 720
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     go,
    input  logic                     cena_in,
    input  logic                     first_in,
    input  logic                     last_in,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] out_data,
    output logic [11:0]              out_addr,
    output logic                     out_wen,
    output logic                     done,
    output logic                     err,
    output logic                     dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [11:0] LAST_ADDR = 12'(NUM_OUTPUTS - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [MEM_LATENCY-1:0]    r_dl_v;
    logic [MEM_LATENCY-1:0]    r_dl_f;
    logic [MEM_LATENCY-1:0]    r_dl_l;
    logic signed [DATA_W-1:0]  r_acc;
    logic                      r_open;
    logic [11:0]               r_wr_cnt;

    logic                      w_v;
    logic                      w_f;
    logic                      w_l;
    logic                      w_orphan;
    logic                      w_write;
    logic                      w_final;
    logic signed [DATA_W-1:0]  w_max;
    logic signed [DATA_W-1:0]  w_result;
    logic signed [DATA_W-1:0]  w_wr_data;

    // The delayed flags line up with din in the same cycle; nothing counts outside RUN.
    assign w_v      = r_dl_v[MEM_LATENCY-1] && (r_state == ST_RUN);
    assign w_f      = r_dl_f[MEM_LATENCY-1];
    assign w_l      = r_dl_l[MEM_LATENCY-1];
    assign w_orphan = w_v && !w_f && !r_open;
    assign w_write  = w_v && w_l && !w_orphan;
    assign w_final  = w_write && (r_wr_cnt == LAST_ADDR);

    assign w_max    = (din > r_acc) ? din : r_acc;
    assign w_result = w_f ? din : w_max;

`ifdef POOL_RELU_EN
    assign w_wr_data = w_result[DATA_W-1] ? '0 : w_result;
`else
    assign w_wr_data = w_result;
`endif

    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (go) begin
                    w_next_state = ST_RUN;
                end else if (w_final) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // go and IDLE flush the line so reset-time iterator flags never look like data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dl_v <= '0;
            r_dl_f <= '0;
            r_dl_l <= '0;
        end else if (go || (r_state == ST_IDLE)) begin
            r_dl_v <= '0;
            r_dl_f <= '0;
            r_dl_l <= '0;
        end else begin
            r_dl_v[0] <= ~cena_in;
            r_dl_f[0] <= first_in;
            r_dl_l[0] <= last_in;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_dl_v[i] <= r_dl_v[i-1];
                r_dl_f[i] <= r_dl_f[i-1];
                r_dl_l[i] <= r_dl_l[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc    <= '0;
            r_open   <= 1'b0;
            r_wr_cnt <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_wen  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            out_wen <= 1'b1;
            done    <= 1'b0;
            if (go) begin
                r_acc    <= '0;
                r_open   <= 1'b0;
                r_wr_cnt <= '0;
                err      <= 1'b0;
            end else if (w_v) begin
                if (w_orphan) begin
                    err <= 1'b1;
                end else begin
                    // A new first while open silently abandons the old window.
                    if (w_f && r_open && !w_l) begin
                        err <= 1'b1;
                    end
                    r_acc <= w_result;
                    if (w_write) begin
                        out_data <= w_wr_data;
                        out_addr <= r_wr_cnt;
                        out_wen  <= 1'b0;
                        done     <= w_final;
                        r_open   <= 1'b0;
                        r_wr_cnt <= w_final ? 12'd0 : r_wr_cnt + 12'd1;
                    end else begin
                        r_open <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_unit.sv
// Bench for max_pool_unit: two instances (SRAM latency 1 and 3, four outputs per layer)
// share one request stream and are checked against a window-level reference model.
module tb_max_pool_unit;

    localparam int W  = 16;
    localparam int LA = 1;
    localparam int LB = 3;
    localparam int N  = 4;
    localparam int EW = 1 + 12 + W;

    logic clk;
    logic rstn;
    logic go;
    logic cena_in;
    logic first_in;
    logic last_in;
    logic signed [W-1:0] req_data;
    logic signed [W-1:0] dhist [0:2];

    logic signed [W-1:0] data_a, data_b;
    logic [11:0]         addr_a, addr_b;
    logic                wen_a, wen_b, done_a, done_b, err_a, err_b, st_a, st_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [EW-1:0]       got_a[$];
    logic [EW-1:0]       got_b[$];
    int                  gcyc_a[$];
    int                  gcyc_b[$];
    logic [EW-1:0]       exp_q[$];
    int                  exp_idx[$];
    bit                  exp_err;
    int                  lcyc[$];

    bit                  rq_c[$];
    bit                  rq_f[$];
    bit                  rq_l[$];
    logic signed [W-1:0] rq_d[$];

    max_pool_unit #(.DATA_W(W), .MEM_LATENCY(LA), .NUM_OUTPUTS(N)) dut_a (
        .clk(clk), .rstn(rstn), .go(go), .cena_in(cena_in), .first_in(first_in),
        .last_in(last_in), .din(dhist[0]), .out_data(data_a), .out_addr(addr_a),
        .out_wen(wen_a), .done(done_a), .err(err_a), .dbg_state(st_a)
    );

    max_pool_unit #(.DATA_W(W), .MEM_LATENCY(LB), .NUM_OUTPUTS(N)) dut_b (
        .clk(clk), .rstn(rstn), .go(go), .cena_in(cena_in), .first_in(first_in),
        .last_in(last_in), .din(dhist[2]), .out_data(data_b), .out_addr(addr_b),
        .out_wen(wen_b), .done(done_b), .err(err_b), .dbg_state(st_b)
    );

    // Clock, cycle counter and the SRAM read-data pipeline
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        dhist[0] <= req_data;
        dhist[1] <= dhist[0];
        dhist[2] <= dhist[1];
    end

    always @(negedge clk) begin
        if (!wen_a || done_a) begin
            got_a.push_back({done_a, addr_a, data_a});
            gcyc_a.push_back(cyc);
        end
        if (!wen_b || done_b) begin
            got_b.push_back({done_b, addr_b, data_b});
            gcyc_b.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            go       = 1'b0;
            cena_in  = 1'b1;
            first_in = 1'($urandom_range(0, 1));
            last_in  = 1'($urandom_range(0, 1));
            req_data = W'($urandom);
        end
    endtask

    task automatic clear_got();
        got_a.delete();
        got_b.delete();
        gcyc_a.delete();
        gcyc_b.delete();
    endtask

    task automatic start_layer();
        @(posedge clk); #1;
        go      = 1'b1;
        cena_in = 1'b1;
        clear_got();
    endtask

    task automatic clear_rq();
        rq_c.delete();
        rq_f.delete();
        rq_l.delete();
        rq_d.delete();
    endtask

    task automatic push(input bit c, input bit f, input bit l, input logic signed [W-1:0] d);
        rq_c.push_back(c);
        rq_f.push_back(f);
        rq_l.push_back(l);
        rq_d.push_back(d);
    endtask

    task automatic drive_seq();
        lcyc.delete();
        for (int i = 0; i < rq_c.size(); i++) begin
            @(posedge clk); #1;
            go       = 1'b0;
            cena_in  = rq_c[i];
            first_in = rq_f[i];
            last_in  = rq_l[i];
            req_data = rq_d[i];
            lcyc.push_back(cyc);
        end
    endtask

    // Reference model: walks the request list window by window
    task automatic model_seq();
        logic signed [W-1:0] mx;
        logic signed [W-1:0] res;
        bit open;
        bit live;
        int cnt;
        open = 0;
        live = 1;
        cnt  = 0;
        mx   = '0;
        exp_err = 0;
        exp_q.delete();
        exp_idx.delete();
        for (int i = 0; i < rq_c.size(); i++) begin
            if (live && !rq_c[i]) begin
                if (!rq_f[i] && !open) begin
                    exp_err = 1;
                end else begin
                    if (rq_f[i]) begin
                        if (open && !rq_l[i]) exp_err = 1;
                        mx   = rq_d[i];
                        open = 1;
                    end else if (rq_d[i] > mx) begin
                        mx = rq_d[i];
                    end
                    if (rq_l[i]) begin
                        res = mx;
`ifdef POOL_RELU_EN
                        if (res < 0) res = '0;
`endif
                        exp_q.push_back({(cnt == N - 1), 12'(cnt), res});
                        exp_idx.push_back(i);
                        open = 0;
                        if (cnt == N - 1) begin
                            live = 0;
                            cnt  = 0;
                        end else begin
                            cnt++;
                        end
                    end
                end
            end
        end
    endtask

    // Tests
    task automatic test_reset();
        n_checks++;
        if ({data_a, addr_a, wen_a, done_a, err_a, st_a} !== {16'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_a: got data=%h addr=%0d wen=%b done=%b err=%b st=%b",
                     data_a, addr_a, wen_a, done_a, err_a, st_a);
        end
        n_checks++;
        if ({data_b, addr_b, wen_b, done_b, err_b, st_b} !== {16'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_b: got data=%h addr=%0d wen=%b done=%b err=%b st=%b",
                     data_b, addr_b, wen_b, done_b, err_b, st_b);
        end
        idle(3);
        n_checks++;
        if (got_a.size() != 0 || got_b.size() != 0) begin
            n_err++;
            $display("FAIL reset_idle_writes: got %0d/%0d expected 0", got_a.size(), got_b.size());
        end
    endtask

    task automatic test_basic_window();
        logic [EW-1:0] gq[$];
        int cq[$];
        int lat;
        clear_rq();
        push(0, 1, 0, 16'sd3);
        push(0, 0, 0, -16'sd7);
        push(0, 0, 0, 16'sd12);
        push(0, 0, 1, 16'sd5);
        model_seq();
        start_layer();
        drive_seq();
        idle(8);
        n_checks++;
        if (exp_q.size() != 1 || exp_q[0] !== {1'b0, 12'd0, 16'sd12}) begin
            n_err++;
            $display("FAIL basic_model: model produced %0d writes", exp_q.size());
        end
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin gq = got_a; cq = gcyc_a; lat = LA; end
            else        begin gq = got_b; cq = gcyc_b; lat = LB; end
            n_checks++;
            if (gq.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL basic[%0d] count: got %0d expected %0d", d, gq.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < gq.size(); k++) begin
                n_checks++;
                if (gq[k] !== exp_q[k] || cq[k] != lcyc[exp_idx[k]] + lat + 1) begin
                    n_err++;
                    $display("FAIL basic[%0d] write%0d: got %h@%0d expected %h@%0d", d, k,
                             gq[k], cq[k], exp_q[k], lcyc[exp_idx[k]] + lat + 1);
                end
            end
        end
        n_checks++;
        if (st_a !== 1'b1 || st_b !== 1'b1 || err_a !== 1'b0 || err_b !== 1'b0) begin
            n_err++;
            $display("FAIL basic_state: got st=%b%b err=%b%b expected st=11 err=00", st_a, st_b, err_a, err_b);
        end
    endtask

    task automatic test_negative_window();
        logic signed [W-1:0] want;
        clear_rq();
        push(0, 1, 0, -16'sd9);
        push(0, 0, 0, -16'sd4);
        push(0, 0, 0, -16'sd20);
        push(0, 0, 1, -16'sd4);
`ifdef POOL_RELU_EN
        want = 16'sd0;
`else
        want = -16'sd4;
`endif
        start_layer();
        drive_seq();
        idle(8);
        n_checks++;
        if (got_a.size() != 1 || got_a[0] !== {1'b0, 12'd0, want}) begin
            n_err++;
            $display("FAIL negative_a: got %0d writes first=%h expected %h", got_a.size(),
                     (got_a.size() > 0) ? got_a[0] : '0, {1'b0, 12'd0, want});
        end
        n_checks++;
        if (got_b.size() != 1 || got_b[0] !== {1'b0, 12'd0, want}) begin
            n_err++;
            $display("FAIL negative_b: got %0d writes first=%h expected %h", got_b.size(),
                     (got_b.size() > 0) ? got_b[0] : '0, {1'b0, 12'd0, want});
        end
    endtask

    task automatic test_latency_single();
        clear_rq();
        push(0, 1, 1, -16'sd1);
        start_layer();
        drive_seq();
        idle(8);
        n_checks++;
        if (got_b.size() != 1 || got_b[0] !== {1'b0, 12'd0, 16'hffff} || gcyc_b[0] != lcyc[0] + 4) begin
            n_err++;
            $display("FAIL latency3_single: got %0d writes %h@%0d expected %h@%0d", got_b.size(),
                     (got_b.size() > 0) ? got_b[0] : '0, (gcyc_b.size() > 0) ? gcyc_b[0] : -1,
                     {1'b0, 12'd0, 16'hffff}, lcyc[0] + 4);
        end
        n_checks++;
        if (got_a.size() != 1 || gcyc_a[0] != lcyc[0] + 2) begin
            n_err++;
            $display("FAIL latency1_single: got %0d writes @%0d expected 1 @%0d", got_a.size(),
                     (gcyc_a.size() > 0) ? gcyc_a[0] : -1, lcyc[0] + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] gq[$];
        int cq[$];
        int lat;
        clear_rq();
        for (int w = 0; w < 4; w++) begin
            for (int e = 0; e < 4; e++) begin
                push(0, (e == 0), (e == 3), W'($urandom));
            end
        end
        model_seq();
        start_layer();
        drive_seq();
        idle(8);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin gq = got_a; cq = gcyc_a; lat = LA; end
            else        begin gq = got_b; cq = gcyc_b; lat = LB; end
            n_checks++;
            if (gq.size() != 4) begin
                n_err++;
                $display("FAIL b2b[%0d] count: got %0d expected 4", d, gq.size());
            end
            for (int k = 0; k < exp_q.size() && k < gq.size(); k++) begin
                n_checks++;
                if (gq[k] !== exp_q[k] || cq[k] != lcyc[exp_idx[k]] + lat + 1) begin
                    n_err++;
                    $display("FAIL b2b[%0d] write%0d: got %h@%0d expected %h@%0d", d, k,
                             gq[k], cq[k], exp_q[k], lcyc[exp_idx[k]] + lat + 1);
                end
            end
        end
        n_checks++;
        if (st_a !== 1'b0 || st_b !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got state %b/%b expected 0/0", st_a, st_b);
        end
        clear_got();
        clear_rq();
        push(0, 1, 1, 16'sd77);
        drive_seq();
        idle(8);
        n_checks++;
        if (got_a.size() != 0 || got_b.size() != 0) begin
            n_err++;
            $display("FAIL b2b_after_done: got %0d/%0d writes expected 0", got_a.size(), got_b.size());
        end
    endtask

    task automatic test_orphan_err();
        logic [EW-1:0] gq[$];
        clear_rq();
        push(0, 0, 0, 16'sd100);
        push(0, 1, 0, 16'sd5);
        push(0, 0, 1, 16'sd6);
        model_seq();
        start_layer();
        drive_seq();
        idle(8);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) gq = got_a;
            else        gq = got_b;
            n_checks++;
            if (gq.size() != 1 || gq[0] !== {1'b0, 12'd0, 16'sd6}) begin
                n_err++;
                $display("FAIL orphan[%0d] write: got %0d writes expected one of 6", d, gq.size());
            end
        end
        n_checks++;
        if (err_a !== 1'b1 || err_b !== 1'b1 || !exp_err) begin
            n_err++;
            $display("FAIL orphan_err: got %b/%b expected 1/1", err_a, err_b);
        end
        clear_rq();
        push(0, 1, 1, 16'sd1);
        drive_seq();
        idle(6);
        n_checks++;
        if (err_a !== 1'b1 || err_b !== 1'b1) begin
            n_err++;
            $display("FAIL orphan_sticky: got %b/%b expected 1/1", err_a, err_b);
        end
        start_layer();
        idle(2);
        n_checks++;
        if (err_a !== 1'b0 || err_b !== 1'b0) begin
            n_err++;
            $display("FAIL orphan_go_clear: got %b/%b expected 0/0", err_a, err_b);
        end
    endtask

    task automatic test_restart();
        logic [EW-1:0] gq[$];
        clear_rq();
        push(0, 1, 0, 16'sd50);
        push(0, 0, 0, 16'sd60);
        push(0, 0, 1, 16'sd70);
        start_layer();
        drive_seq();
        start_layer();
        clear_rq();
        push(0, 1, 0, 16'sd7);
        push(0, 0, 1, 16'sd8);
        model_seq();
        drive_seq();
        idle(8);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) gq = got_a;
            else        gq = got_b;
            n_checks++;
            if (gq.size() != 1 || gq[0] !== exp_q[0]) begin
                n_err++;
                $display("FAIL restart[%0d]: got %0d writes first=%h expected 1 of %h", d, gq.size(),
                         (gq.size() > 0) ? gq[0] : '0, exp_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        clear_rq();
        push(0, 1, 0, 16'sd10);
        push(0, 0, 0, 16'sd20);
        start_layer();
        drive_seq();
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({data_a, addr_a, wen_a, done_a, err_a, st_a, data_b, addr_b, wen_b, done_b, err_b, st_b} !==
            {16'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_values: got a=%h/%0d/%b b=%h/%0d/%b expected 0/0/1",
                     data_a, addr_a, wen_a, data_b, addr_b, wen_b);
        end
        idle(3);
        @(negedge clk) rstn = 1'b1;
        idle(4);
        n_checks++;
        if (got_a.size() != 0 || got_b.size() != 0) begin
            n_err++;
            $display("FAIL midreset_stale: got %0d/%0d writes expected 0", got_a.size(), got_b.size());
        end
        clear_rq();
        push(0, 1, 0, 16'sd1);
        push(0, 0, 0, 16'sd2);
        push(0, 0, 0, 16'sd3);
        push(0, 0, 1, 16'sd4);
        start_layer();
        drive_seq();
        idle(8);
        n_checks++;
        if (got_a.size() != 1 || got_a[0] !== {1'b0, 12'd0, 16'sd4} ||
            got_b.size() != 1 || got_b[0] !== {1'b0, 12'd0, 16'sd4}) begin
            n_err++;
            $display("FAIL midreset_window: got %0d/%0d writes expected one of 4 at addr 0",
                     got_a.size(), got_b.size());
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] gq[$];
        int cq[$];
        int lat;
        int nw;
        int sz;
        bit e_got;
        for (int it = 0; it < 25; it++) begin
            clear_rq();
            nw = $urandom_range(2, 6);
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, 2)) push(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
                if ($urandom_range(0, 9) == 0) push(0, 0, 1'($urandom_range(0, 1)), W'($urandom));
                if ($urandom_range(0, 7) == 0) push(0, 1, 0, W'($urandom));
                sz = $urandom_range(1, 4);
                for (int e = 0; e < sz; e++) begin
                    push(0, (e == 0), (e == sz - 1), W'($urandom));
                end
            end
            model_seq();
            start_layer();
            drive_seq();
            idle(8);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin gq = got_a; cq = gcyc_a; lat = LA; e_got = err_a; end
                else        begin gq = got_b; cq = gcyc_b; lat = LB; e_got = err_b; end
                n_checks++;
                if (gq.size() != exp_q.size() || e_got !== exp_err) begin
                    n_err++;
                    $display("FAIL random%0d[%0d] count/err: got %0d/%b expected %0d/%b", it, d,
                             gq.size(), e_got, exp_q.size(), exp_err);
                end
                for (int k = 0; k < exp_q.size() && k < gq.size(); k++) begin
                    n_checks++;
                    if (gq[k] !== exp_q[k] || cq[k] != lcyc[exp_idx[k]] + lat + 1) begin
                        n_err++;
                        $display("FAIL random%0d[%0d] write%0d: got %h@%0d expected %h@%0d", it, d, k,
                                 gq[k], cq[k], exp_q[k], lcyc[exp_idx[k]] + lat + 1);
                    end
                end
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        go       = 1'b0;
        cena_in  = 1'b1;
        first_in = 1'b1;
        last_in  = 1'b1;
        req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        test_reset();
        test_basic_window();
        test_negative_window();
        test_latency_single();
        test_back_to_back();
        test_orphan_err();
        test_restart();
        test_reset_mid_window();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
